// File: rtl/mmwave_pkg.sv
// mmwave_pkg: state encoding and shared constants for the mmWave sample packer.
package mmwave_pkg;
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEQ, S_LEN, S_SMP_HI, S_SMP_LO, S_CHK} state_t;
    localparam logic [7:0]  HDR_BYTE_DEF = 8'hA5;
    localparam logic [15:0] DROP_SAT     = 16'hFFFF;
endpackage

// File: rtl/mmwave_sample_fifo.sv
// mmwave_sample_fifo: 13-bit first-word-fall-through sample FIFO.
// Also exposes the entry behind the head so the packer can preload the next sample without a bubble.
module mmwave_sample_fifo #(
    parameter int DEPTH = 512,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [12:0]   data_i,
    output logic [12:0]   data_o,
    output logic [12:0]   next_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);
    logic [12:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd, w_rd_nxt;
    logic [LW-1:0] r_level;
    logic          w_wr, w_rd;

    assign full_o   = r_level == LW'(DEPTH);
    assign empty_o  = r_level == '0;
    assign level_o  = r_level;
    assign w_rd     = pop_i & ~empty_o;
    assign w_wr     = push_i & (~full_o | w_rd);
    assign w_rd_nxt = r_rd + AW'(1);
    assign data_o   = r_mem[r_rd];
    assign next_o   = r_mem[w_rd_nxt];

    always_ff @(posedge clk)
        if (w_wr) r_mem[r_wr] <= data_i;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + AW'(1);
            if (w_rd) r_rd <= w_rd_nxt;
            r_level <= r_level + LW'(w_wr) - LW'(w_rd);
        end
endmodule

// File: rtl/mmwave_sample_packer.sv
// mmwave_sample_packer: frames buffered 13-bit samples into HDR/SEQ/LEN/sample byte packets.
// Define MMWAVE_PACK_CHKSUM_EN to append an XOR checksum byte to every packet.
module mmwave_sample_packer
    import mmwave_pkg::*;
#(
    parameter int         FIFO_DEPTH = 512,
    parameter logic [7:0] HDR_BYTE   = HDR_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [7:0]  pack_len_i,
    input  logic        sample_valid_i,
    input  logic [12:0] sample_data_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic        busy_o,
    output logic        overflow_o,
    output logic [15:0] drop_cnt_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_byte, w_byte_nxt, r_seq, r_len;
    logic [8:0]    r_cnt, w_need;
    logic [15:0]   r_drop;
    logic [12:0]   w_head, w_next;
    logic [LW-1:0] w_level;
    logic          r_valid, r_ovf;
    logic          w_push, w_pop, w_full, w_empty, w_acc, w_start, w_done, w_drop;

    assign w_push  = sample_valid_i & en_i;
    assign w_drop  = w_push & w_full & ~w_pop;
    assign w_acc   = r_valid & byte_ready_i;
    assign w_need  = (pack_len_i == 8'd0) ? 9'd256 : {1'b0, pack_len_i};
    assign w_start = (r_state == S_IDLE) && (w_level >= LW'(w_need));
    assign w_pop   = w_acc & (r_state == S_SMP_LO) & ~w_empty;

    assign byte_o       = r_byte;
    assign byte_valid_o = r_valid;
    assign busy_o       = r_state != S_IDLE;
    assign overflow_o   = r_ovf;
    assign drop_cnt_o   = r_drop;

    mmwave_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .data_i  (sample_data_i),
        .data_o  (w_head),
        .next_o  (w_next),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (w_level)
    );

`ifdef MMWAVE_PACK_CHKSUM_EN
    logic [7:0] r_chk;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_chk <= '0;
        else if (w_start) r_chk <= '0;
        else if (w_acc) r_chk <= r_chk ^ r_byte;
`endif

    // The byte register is loaded on the transition into a state, so each state's byte is presented while in it.
    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start) begin w_state_nxt = S_HDR; w_byte_nxt = HDR_BYTE; end
            S_HDR:    if (w_acc) begin w_state_nxt = S_SEQ; w_byte_nxt = r_seq; end
            S_SEQ:    if (w_acc) begin w_state_nxt = S_LEN; w_byte_nxt = r_len; end
            S_LEN:    if (w_acc) begin w_state_nxt = S_SMP_HI; w_byte_nxt = {3'b000, w_head[12:8]}; end
            S_SMP_HI: if (w_acc) begin w_state_nxt = S_SMP_LO; w_byte_nxt = w_head[7:0]; end
            S_SMP_LO: if (w_acc) begin
                if (r_cnt != 9'd1) begin
                    w_state_nxt = S_SMP_HI;
                    w_byte_nxt  = {3'b000, w_next[12:8]};
                end else begin
`ifdef MMWAVE_PACK_CHKSUM_EN
                    w_state_nxt = S_CHK;
                    w_byte_nxt  = r_chk ^ r_byte;
`else
                    w_state_nxt = S_IDLE;
                    w_byte_nxt  = 8'h00;
                    w_done      = 1'b1;
`endif
                end
            end
`ifdef MMWAVE_PACK_CHKSUM_EN
            S_CHK:    if (w_acc) begin w_state_nxt = S_IDLE; w_byte_nxt = 8'h00; w_done = 1'b1; end
`endif
            default:  begin w_state_nxt = S_IDLE; w_byte_nxt = 8'h00; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_seq   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_byte  <= w_byte_nxt;
            r_valid <= w_state_nxt != S_IDLE;
            if (w_start) begin
                r_len <= pack_len_i;
                r_cnt <= w_need;
            end else if (w_pop) r_cnt <= r_cnt - 9'd1;
            if (w_done) r_seq <= r_seq + 8'd1;
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != DROP_SAT) r_drop <= r_drop + 16'd1;
            end
        end
endmodule

// File: tb/tb_mmwave_sample_packer.sv
// tb_mmwave_sample_packer: directed bench for framing, backpressure, overflow, sequence wrap and reset abort.
module tb_mmwave_sample_packer;
    logic        clk = 1'b0, rst_n = 1'b0, en_i = 1'b0, sample_valid_i = 1'b0, byte_ready_i = 1'b0;
    logic [7:0]  pack_len_i = 8'd0;
    logic [12:0] sample_data_i = 13'd0;
    logic [7:0]  byte_o;
    logic        byte_valid_o, busy_o, overflow_o;
    logic [15:0] drop_cnt_o;

    int          n_chk = 0, n_pass = 0;
    logic [12:0] q[$];
    logic [7:0]  seq = 8'd0;
    logic [7:0]  b;

    mmwave_sample_packer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (en_i),
        .pack_len_i     (pack_len_i),
        .sample_valid_i (sample_valid_i),
        .sample_data_i  (sample_data_i),
        .byte_o         (byte_o),
        .byte_valid_o   (byte_valid_o),
        .byte_ready_i   (byte_ready_i),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    endtask

    task automatic push(input logic [12:0] d, input bit keep);
        sample_valid_i = 1'b1;
        sample_data_i  = d;
        @(negedge clk);
        sample_valid_i = 1'b0;
        if (keep) q.push_back(d);
    endtask

    // Called and returns on a falling edge; the returned byte was accepted on the rising edge in between.
    task automatic get_byte(input bit rnd, output logic [7:0] ob);
        bit         stalled = 1'b0;
        logic [7:0] held = 8'h00;
        ob = 8'hxx;
        for (int t = 0; t < 4000; t++) begin
            if (stalled) begin
                chk("stall_hold", t, 32'(byte_o), 32'(held));
                chk("stall_valid", t, 32'(byte_valid_o), 32'd1);
            end
            byte_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (byte_valid_o && byte_ready_i) begin
                ob = byte_o;
                @(negedge clk);
                return;
            end
            stalled = byte_valid_o;
            held    = byte_o;
            @(negedge clk);
        end
        n_chk++;
        $error("FAIL byte_timeout observed=no_byte expected=byte_within_4000_cycles");
    endtask

    task automatic check_packet(input logic [7:0] len, input int n, input bit rnd,
                                input int poke_at, input logic [7:0] poke_val);
        logic [7:0]  e[$];
        logic [12:0] d;
        logic [7:0]  x;
        logic [7:0]  ob;
        e.push_back(8'hA5);
        e.push_back(seq);
        e.push_back(len);
        for (int i = 0; i < n; i++) begin
            d = q.pop_front();
            e.push_back({3'b000, d[12:8]});
            e.push_back(d[7:0]);
        end
`ifdef MMWAVE_PACK_CHKSUM_EN
        x = 8'h00;
        foreach (e[i]) x ^= e[i];
        e.push_back(x);
`else
        x = 8'h00;
`endif
        for (int i = 0; i < e.size(); i++) begin
            get_byte(rnd, ob);
            if (i == poke_at) pack_len_i = poke_val;
            chk("pkt_byte", i, 32'(ob), 32'(e[i]));
        end
        chk("idle_gap_valid", int'(seq), 32'(byte_valid_o), 32'd0);
        chk("idle_gap_busy", int'(seq), 32'(busy_o), 32'd0);
        seq = seq + 8'd1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 0, 32'(byte_valid_o), 32'd0);
        chk("rst_byte", 0, 32'(byte_o), 32'd0);
        chk("rst_busy", 0, 32'(busy_o), 32'd0);
        chk("rst_ovf", 0, 32'(overflow_o), 32'd0);
        chk("rst_drop", 0, 32'(drop_cnt_o), 32'd0);
        rst_n = 1'b1;
        en_i  = 1'b1;
        @(negedge clk);

        // Basic packet: A5 00 04 1A BC 00 01 1F FF 00 00
        pack_len_i   = 8'd4;
        byte_ready_i = 1'b1;
        push(13'h1ABC, 1'b1); push(13'h0001, 1'b1); push(13'h1FFF, 1'b1); push(13'h0000, 1'b1);
        check_packet(8'd4, 4, 1'b0, -1, 8'd0);

        // Same samples under random backpressure
        push(13'h1ABC, 1'b1); push(13'h0001, 1'b1); push(13'h1FFF, 1'b1); push(13'h0000, 1'b1);
        check_packet(8'd4, 4, 1'b1, -1, 8'd0);

        // Overflow: 520 samples into a 512-deep FIFO while the consumer is stalled
        byte_ready_i = 1'b0;
        pack_len_i   = 8'd0;
        for (int i = 0; i < 520; i++) push(13'(i * 37 + 5), i < 512);
        chk("ovf_flag", 0, 32'(overflow_o), 32'd1);
        chk("drop_cnt", 0, 32'(drop_cnt_o), 32'd8);
        check_packet(8'd0, 256, 1'b1, 10, 8'd5);
        pack_len_i = 8'd0;
        check_packet(8'd0, 256, 1'b0, -1, 8'd0);
        chk("ovf_sticky", 0, 32'(overflow_o), 32'd1);

        // Reset in the middle of a packet
        pack_len_i = 8'd4;
        push(13'h1ABC, 1'b1); push(13'h0001, 1'b1); push(13'h0002, 1'b1); push(13'h0003, 1'b1);
        get_byte(1'b0, b); chk("mid_hdr", 0, 32'(b), 32'hA5);
        get_byte(1'b0, b); chk("mid_seq", 0, 32'(b), 32'(seq));
        get_byte(1'b0, b); chk("mid_len", 0, 32'(b), 32'h04);
        byte_ready_i = 1'b0;
        chk("mid_byte", 0, 32'(byte_o), 32'h1A);
        chk("mid_busy", 0, 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 0, 32'(byte_valid_o), 32'd0);
        chk("abort_byte", 0, 32'(byte_o), 32'd0);
        chk("abort_busy", 0, 32'(busy_o), 32'd0);
        chk("abort_ovf", 0, 32'(overflow_o), 32'd0);
        chk("abort_drop", 0, 32'(drop_cnt_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        seq = 8'd0;
        @(negedge clk);
        push(13'h0ABC, 1'b1); push(13'h1234, 1'b1); push(13'h0F0F, 1'b1); push(13'h1555, 1'b1);
        check_packet(8'd4, 4, 1'b0, -1, 8'd0);

        // Sequence wrap with single-sample packets
        pack_len_i = 8'd1;
        for (int k = 0; k < 257; k++) begin
            push(13'(k * 29 + 1), 1'b1);
            check_packet(8'd1, 1, 1'b0, -1, 8'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
